lcd12864_bus_writer: RTL and testbench
======================================

// Module: lcd12864_bus_writer
// PURPOSE
// - Physical-bus stage for the 12864 (ST7920-class) LCD in 8-bit parallel mode.
// - Sits between any command/text sequencer and the LCD pins.
// - Accepts one {rs, byte} write per valid/ready handshake and generates timed rs/dat/en strobes.
// - Waits out the controller execution time; handles power-up reset sequencing of the panel.
// PARAMETERS
// CNT_W    24         width of the internal delay counter
// T_RST    5000       cycles lcd_rst held low after reset (100 us @ 50 MHz)
// T_PWRUP  2500000    cycles waited after lcd_rst release before first accept (50 ms)
// T_SETUP  4          cycles rs/dat stable before en rises
// T_EN     25         cycles en held high
// T_HOLD   4          cycles rs/dat held after en falls
// T_EXEC   4000       execution wait, normal command/data (80 us)
// T_CLEAR  80000      execution wait for rs=0 && byte==8'h01 or 8'h02 (1.6 ms)
// - All T_* >= 1 and < 2**CNT_W.
// PORTS
// clk        in   1  system clock, single domain
// rst_n      in   1  synchronous active-low reset
// in_valid   in   1  write request
// in_rs      in   1  0 = instruction, 1 = data
// in_data    in   8  byte to write
// in_ready   out  1  high when a request can be accepted
// busy       out  1  ~in_ready
// rs         out  1  LCD RS
// rw         out  1  LCD R/W, constant 0 (write only)
// en         out  1  LCD E
// dat        out  8  LCD DB7..DB0
// lcd_rst    out  1  LCD reset, active low
// psb        out  1  constant 1 (parallel mode)
// BEHAVIOUR
// - Reset values: in_ready=0, busy=1, rs=0, rw=0, en=0, dat=8'h00, lcd_rst=0, psb=1, state=RST.
// - Reset applies on any clk edge with rst_n=0, including mid-transaction:
//   en drops that edge; the sequence restarts at RST.
// - Each state lasts exactly its T_* cycles; the counter loads T_*-1 on entry, counts to 0, then advances.
// - FSM:
//   - RST: lcd_rst=0 for T_RST cycles -> PWRUP.
//   - PWRUP: lcd_rst=1, wait T_PWRUP -> IDLE.
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch rs<=in_rs, dat<=in_data -> SETUP.
//   - SETUP: en=0 for T_SETUP -> STROBE.
//   - STROBE: en=1 for T_EN -> HOLD.
//   - HOLD: en=0, rs/dat unchanged for T_HOLD -> EXEC.
//   - EXEC: wait T_CLEAR if latched rs=0 and dat in {01,02}, else T_EXEC -> IDLE.
// - in_ready is registered; it falls on the accept edge and stays 0 for T_SETUP+T_EN+T_HOLD+T_wait cycles.
// - One accept per IDLE visit. in_valid held high back-to-back gives exactly one write per pass.
// - in_valid outside IDLE is ignored, not queued. Upstream must hold the request until ready.
// - rs/dat change only on the accept edge; they keep the last written value while IDLE.
// - en is registered and glitch-free; exactly one rising edge per accepted write.
// TESTING (bench params: T_RST=3 T_PWRUP=5 T_SETUP=2 T_EN=3 T_HOLD=2 T_EXEC=4 T_CLEAR=10)
// - Reset release -> lcd_rst low 3 cycles, high; in_ready rises 5 cycles later; en/rs/dat stay 0.
// - Write rs=1 0x57 -> rs=1 dat=0x57 next cycle; en=0 2 cyc, en=1 3 cyc, 0; in_ready back after 11 cyc.
// - Write rs=0 0x01 -> same strobe; in_ready low 17 cycles (CLEAR wait).
// - Write rs=1 0x01 -> normal 11-cycle busy (data, not clear).
// - in_valid held high with 0x30,0x0C,0x06 sequence -> three en pulses in order, each after in_ready.
// - rst_n low during STROBE -> en=0, lcd_rst=0, in_ready=0 next edge; full power-up repeats.

Source files
------------

// File: rtl/lcd12864_bus_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd12864_bus_writer_if
// Description : Write-request handshake plus LCD pin bundle for the 12864
//               parallel-bus writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd12864_bus_writer_if;
    logic       in_valid;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] dat;
    logic       lcd_rst;
    logic       psb;

    modport master (
        output in_valid, in_rs, in_data,
        input  in_ready, busy, rs, rw, en, dat, lcd_rst, psb
    );

    modport slave (
        input  in_valid, in_rs, in_data,
        output in_ready, busy, rs, rw, en, dat, lcd_rst, psb
    );
endinterface
`default_nettype wire

// File: rtl/lcd12864_bus_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd12864_bus_writer
// Description : Timed RS/DB/E strobe generator for an ST7920-class 12864 LCD
//               in 8-bit parallel mode, including panel power-up sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd12864_bus_writer #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned T_RST   = 5000,
    parameter int unsigned T_PWRUP = 2500000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_EXEC  = 4000,
    parameter int unsigned T_CLEAR = 80000
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    lcd12864_bus_writer_if.slave        bus
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_PWRUP  = 3'd1,
        S_IDLE   = 3'd2,
        S_SETUP  = 3'd3,
        S_STROBE = 3'd4,
        S_HOLD   = 3'd5,
        S_EXEC   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_LD_RST   = CNT_W'(T_RST   - 1);
    localparam logic [CNT_W-1:0] c_LD_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] c_LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] c_LD_EN    = CNT_W'(T_EN    - 1);
    localparam logic [CNT_W-1:0] c_LD_HOLD  = CNT_W'(T_HOLD  - 1);
    localparam logic [CNT_W-1:0] c_LD_EXEC  = CNT_W'(T_EXEC  - 1);
    localparam logic [CNT_W-1:0] c_LD_CLEAR = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_cnt_zero;
    logic               w_accept;
    logic               w_long_wait;
    logic               r_ready;
    logic               r_en;
    logic               r_rs;
    logic [7:0]         r_dat;
    logic               r_lcd_rst;

    assign w_cnt_zero  = (r_cnt == '0);
    // Clear-display and return-home instructions need the long execution wait.
    assign w_long_wait = !r_rs && ((r_dat == 8'h01) || (r_dat == 8'h02));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_RST: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_PWRUP;
                    w_cnt_nxt   = c_LD_PWRUP;
                end else begin
                    w_cnt_nxt   = r_cnt - c_ONE;
                end
            end
            S_PWRUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - c_ONE;
                end
            end
            S_IDLE: begin
                if (bus.in_valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_LD_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = c_LD_EN;
                end else begin
                    w_cnt_nxt   = r_cnt - c_ONE;
                end
            end
            S_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_LD_HOLD;
                end else begin
                    w_cnt_nxt   = r_cnt - c_ONE;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_EXEC;
                    w_cnt_nxt   = w_long_wait ? c_LD_CLEAR : c_LD_EXEC;
                end else begin
                    w_cnt_nxt   = r_cnt - c_ONE;
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - c_ONE;
                end
            end
            default: begin
                w_state_nxt = S_RST;
                w_cnt_nxt   = c_LD_RST;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they are registered and glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_cnt     <= c_LD_RST;
            r_ready   <= 1'b0;
            r_en      <= 1'b0;
            r_rs      <= 1'b0;
            r_dat     <= 8'h00;
            r_lcd_rst <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_en      <= (w_state_nxt == S_STROBE);
            r_lcd_rst <= (w_state_nxt != S_RST);
            if (w_accept) begin
                r_rs  <= bus.in_rs;
                r_dat <= bus.in_data;
            end
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.busy     = ~r_ready;
    assign bus.rs       = r_rs;
    assign bus.rw       = 1'b0;
    assign bus.en       = r_en;
    assign bus.dat      = r_dat;
    assign bus.lcd_rst  = r_lcd_rst;
    assign bus.psb      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lcd12864_bus_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd12864_bus_writer
// Description : Scoreboard bench for lcd12864_bus_writer with random writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd12864_bus_writer;

    localparam int T_RST   = 3;
    localparam int T_PWRUP = 5;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 4;
    localparam int T_CLEAR = 10;
    localparam int BOUND   = 200;

    typedef struct {
        logic       rs;
        logic [7:0] dat;
        int         busy;
    } exp_t;

    logic clk;
    logic rst_n;
    lcd12864_bus_writer_if bus();

    lcd12864_bus_writer #(
        .CNT_W  (24),
        .T_RST  (T_RST),
        .T_PWRUP(T_PWRUP),
        .T_SETUP(T_SETUP),
        .T_EN   (T_EN),
        .T_HOLD (T_HOLD),
        .T_EXEC (T_EXEC),
        .T_CLEAR(T_CLEAR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int   errors   = 0;
    int   checks   = 0;
    int   n_acc    = 0;
    int   en_rises = 0;
    bit   mon_en   = 1'b1;
    bit   mon_busy = 1'b0;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference timing: the busy window is the sum of the strobe phases plus the execution wait.
    function automatic int exp_busy(input logic rs, input logic [7:0] d);
        int wait_t;
        wait_t = (!rs && (d == 8'h01 || d == 8'h02)) ? T_CLEAR : T_EXEC;
        return T_SETUP + T_EN + T_HOLD + wait_t;
    endfunction

    // Called at the negedge where rst_n was just released.
    task automatic measure_powerup(input string tag);
        int n;
        n = 0;
        while (!bus.lcd_rst && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " lcd_rst low cycles"}, n, T_RST);
        n = 0;
        while (!bus.in_ready && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " pwrup wait cycles"}, n, T_PWRUP);
        chk({tag, " en idle"}, int'(bus.en), 0);
        chk({tag, " rs idle"}, int'(bus.rs), 0);
        chk({tag, " dat idle"}, int'(bus.dat), 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit drop);
        int w;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = d;
        w = 0;
        while (!bus.in_ready && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("ready timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        e.rs   = rs;
        e.dat  = d;
        e.busy = exp_busy(rs, d);
        exp_q.push_back(e);
        n_acc++;
        @(posedge clk);
        #1;
        if (drop) bus.in_valid = 1'b0;
    endtask

    // Counts every en rising edge so spurious or missing pulses show up at the end.
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.en && !prev_en) en_rises++;
            prev_en = bus.en;
        end
    end

    // Monitor: a falling in_ready marks an accept; pop and check that write's strobe.
    initial begin
        logic prev_ready;
        exp_t e;
        int   s, first, hi;
        bit   stable;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && prev_ready && !bus.in_ready) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected accept", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latched rs", int'(bus.rs), int'(e.rs));
                    chk("latched dat", int'(bus.dat), int'(e.dat));
                    chk("busy vs ready", int'(bus.busy), 1);
                    chk("rw/psb", int'({bus.rw, bus.psb}), 1);
                    s = 0; first = -1; hi = 0; stable = 1'b1;
                    while (!bus.in_ready && s < BOUND) begin
                        if (bus.en) begin
                            hi++;
                            if (first < 0) first = s;
                        end
                        if (bus.rs !== e.rs || bus.dat !== e.dat) stable = 1'b0;
                        s++;
                        @(negedge clk);
                    end
                    chk("setup cycles", first, T_SETUP);
                    chk("en high cycles", hi, T_EN);
                    chk("ready low cycles", s, e.busy);
                    chk("rs/dat stable", int'(stable), 1);
                    chk("idle rs/dat kept", int'({bus.rs, bus.dat}), int'({e.rs, e.dat}));
                end
                mon_busy = 1'b0;
            end
            prev_ready = bus.in_ready;
        end
    end

    initial begin
        int   w;
        logic rs;
        logic [7:0] d;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rs    = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst in_ready", int'(bus.in_ready), 0);
        chk("rst busy", int'(bus.busy), 1);
        chk("rst en", int'(bus.en), 0);
        chk("rst rs/dat", int'({bus.rs, bus.dat}), 0);
        chk("rst lcd_rst", int'(bus.lcd_rst), 0);
        chk("rst rw/psb", int'({bus.rw, bus.psb}), 1);
        rst_n = 1'b1;
        measure_powerup("boot");

        send(1'b1, 8'h57, 1'b1);
        send(1'b0, 8'h01, 1'b1);
        send(1'b1, 8'h01, 1'b1);
        send(1'b0, 8'h02, 1'b1);
        send(1'b1, 8'h02, 1'b1);
        send(1'b0, 8'h30, 1'b0);
        send(1'b0, 8'h0C, 1'b0);
        send(1'b0, 8'h06, 1'b1);

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            send(rs, d, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        while ((exp_q.size() != 0 || mon_busy || !bus.in_ready) && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        chk("drain", int'(exp_q.size()), 0);

        // Reset in the middle of the en pulse.
        mon_en = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_rs    = 1'b1;
        bus.in_data  = 8'hA5;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_acc++;
        w = 0;
        @(negedge clk);
        while (!bus.en && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        chk("en before mid reset", int'(bus.en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset en", int'(bus.en), 0);
        chk("mid reset lcd_rst", int'(bus.lcd_rst), 0);
        chk("mid reset in_ready", int'(bus.in_ready), 0);
        chk("mid reset rs/dat", int'({bus.rs, bus.dat}), 0);
        rst_n = 1'b1;
        measure_powerup("rerun");
        mon_en = 1'b1;

        send(1'b1, 8'h41, 1'b1);
        w = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || mon_busy || !bus.in_ready) && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        chk("final drain", int'(exp_q.size()), 0);
        chk("en pulse count", en_rises, n_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
